// File: rtl/i2c_slave_regif.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regif
// Purpose  : I2C target that maps START / device address / register address /
//            data / STOP onto an 8-bit-addressed local register file through
//            a one-cycle write strobe and a combinational read port.
//            SCL and SDA are oversampled on the system clock; SCL is never
//            driven (no clock stretching).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regif #(
  parameter logic [6:0] DEV_ID = 7'h42
) (
  input  logic       clock_freq,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_REG       = 4'd3;
  localparam logic [3:0] S_REG_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_IGNORE    = 4'd9;

  // Synchronizer and history flops (idle bus level is 1)
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  logic [3:0] state_q,   state_d;
  logic [2:0] bitcnt_q,  bitcnt_d;
  logic [7:0] shreg_q,   shreg_d;
  logic       rw_q,      rw_d;
  logic       ack_ph_q,  ack_ph_d;   // ACK slot: 0 = waiting to drive/sample, 1 = in slot
  logic [7:0] ptr_q,     ptr_d;
  logic       sda_oe_q,  sda_oe_d;
  logic       wr_en_q,   wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       busy_q,    busy_d;

  logic       scl_rise, scl_fall;
  logic       start_det, stop_det;
  logic [7:0] byte_in;

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clock_freq or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_in;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  // Our own pull-down only ever moves SDA while SCL is low, but gating on
  // sda_oe keeps a self-inflicted SDA edge from ever being taken as START/STOP.
  assign start_det = ~sda_oe_q & scl_s2_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = ~sda_oe_q & scl_s2_q & ~sda_h_q & sda_s2_q;
  assign byte_in   = {shreg_q[6:0], sda_s2_q};

  // Protocol state machine: next-state and output decode
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    rw_d      = rw_q;
    ack_ph_d  = ack_ph_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;

    if (start_det) begin
      state_d  = S_ADDR;
      bitcnt_d = 3'd7;
      sda_oe_d = 1'b0;
      ack_ph_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      ack_ph_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_IGNORE: begin
          sda_oe_d = 1'b0;
        end

        S_ADDR: begin
          sda_oe_d = 1'b0;
          if (scl_rise) begin
            shreg_d = byte_in;
            if (bitcnt_q == 3'd0) begin
              rw_d     = byte_in[0];
              ack_ph_d = 1'b0;
              // Address 0 (general call) is never answered
              if (byte_in[7:1] == DEV_ID && byte_in[7:1] != 7'd0) begin
                state_d = S_ADDR_ACK;
              end else begin
                state_d = S_IGNORE;
              end
            end else begin
              bitcnt_d = bitcnt_q - 3'd1;
            end
          end
        end

        S_REG, S_WDATA: begin
          sda_oe_d = 1'b0;
          if (scl_rise) begin
            shreg_d = byte_in;
            if (bitcnt_q == 3'd0) begin
              ack_ph_d = 1'b0;
              if (state_q == S_REG) begin
                ptr_d   = byte_in;
                state_d = S_REG_ACK;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                state_d   = S_WDATA_ACK;
              end
            end else begin
              bitcnt_d = bitcnt_q - 3'd1;
            end
          end
        end

        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              ack_ph_d = 1'b0;
              bitcnt_d = 3'd7;
              sda_oe_d = 1'b0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                // Read: present bit 7 immediately as the ACK slot ends
                shreg_d  = rd_data;
                sda_oe_d = ~rd_data[7];
                state_d  = S_RDATA;
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_REG;
              end else if (state_q == S_REG_ACK) begin
                state_d = S_WDATA;
              end else begin
                ptr_d   = ptr_q + 8'd1;
                state_d = S_WDATA;
              end
            end
          end
        end

        S_RDATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              ack_ph_d = 1'b0;
              state_d  = S_RDATA_ACK;
            end else begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
              bitcnt_d = bitcnt_q - 3'd1;
            end
          end
        end

        S_RDATA_ACK: begin
          if (!ack_ph_q && scl_rise) begin
            ptr_d = ptr_q + 8'd1;
            if (sda_s2_q) begin
              state_d = S_IGNORE;
            end else begin
              ack_ph_d = 1'b1;
            end
          end else if (ack_ph_q && scl_fall) begin
            // Pointer has already advanced, so rd_data is the next register
            shreg_d  = rd_data;
            sda_oe_d = ~rd_data[7];
            bitcnt_d = 3'd7;
            ack_ph_d = 1'b0;
            state_d  = S_RDATA;
          end
        end

        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock_freq or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bitcnt_q  <= 3'd7;
      shreg_q   <= 8'h00;
      rw_q      <= 1'b0;
      ack_ph_q  <= 1'b0;
      ptr_q     <= 8'h00;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      rw_q      <= rw_d;
      ack_ph_q  <= ack_ph_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = ptr_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire
